// File: rtl/sort_pkg.sv
// Shared definitions for the serial frame sorter: state encoding,
// sort-order names and the pointer-width helper.
package sort_pkg;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_SORT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        S_LOAD  = ST_LOAD,
        S_SORT  = ST_SORT,
        S_DRAIN = ST_DRAIN
    } state_t;

    localparam string COM_UP   = "UP";
    localparam string COM_DOWN = "DOWN";

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sort_frame_serial_com_logic.sv
// Combinational compare-exchange element: o_first gets the word that belongs
// in the lower slot for the selected order; equal words pass straight through.
module com_logic
    import sort_pkg::*;
#(
    parameter int    DATA_WIDTH = 64,
    parameter string COM_STYLE  = "UP"
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_first,
    output logic [DATA_WIDTH-1:0] o_second
);

    localparam bit ASCEND = (COM_STYLE == COM_UP);

    logic w_swap;

    // Strict compares, so ties never exchange.
    assign w_swap   = ASCEND ? (i_a > i_b) : (i_a < i_b);
    assign o_first  = w_swap ? i_b : i_a;
    assign o_second = w_swap ? i_a : i_b;

endmodule

// File: rtl/sort_frame_serial.sv
// Frame sorter: loads DEPTH words, runs DEPTH odd-even transposition phases
// in place, then streams the sorted frame out.
module sort_frame_serial
    import sort_pkg::*;
#(
    parameter int    DATA_WIDTH = 64,
    parameter int    DEPTH      = 8,
    parameter string COM_STYLE  = "UP"
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    localparam int            PW   = ptr_width(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    // Handshake: a word moves on an edge where valid && ready are both high;
    // ready/valid outputs come only from state, never from the partner's signal.
    state_t                r_state, w_next_state;
    logic [DATA_WIDTH-1:0] r_buf    [DEPTH];
    logic [DATA_WIDTH-1:0] w_even   [DEPTH];
    logic [DATA_WIDTH-1:0] w_odd    [DEPTH];
    logic [DATA_WIDTH-1:0] w_sorted [DEPTH];
    logic [PW-1:0]         r_wr_ptr, r_phase, r_rd_ptr;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH / 2; gi++) begin : g_even
            com_logic #(.DATA_WIDTH(DATA_WIDTH), .COM_STYLE(COM_STYLE)) u_cmp (
                .i_a      (r_buf[2*gi]),
                .i_b      (r_buf[2*gi+1]),
                .o_first  (w_even[2*gi]),
                .o_second (w_even[2*gi+1])
            );
        end
        for (gi = 0; gi < DEPTH / 2 - 1; gi++) begin : g_odd
            com_logic #(.DATA_WIDTH(DATA_WIDTH), .COM_STYLE(COM_STYLE)) u_cmp (
                .i_a      (r_buf[2*gi+1]),
                .i_b      (r_buf[2*gi+2]),
                .o_first  (w_odd[2*gi+1]),
                .o_second (w_odd[2*gi+2])
            );
        end
        for (gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign w_sorted[gi] = r_phase[0] ? w_odd[gi] : w_even[gi];
        end
    endgenerate

    // End slots sit out the odd phase.
    assign w_odd[0]       = r_buf[0];
    assign w_odd[DEPTH-1] = r_buf[DEPTH-1];

    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        busy         = 1'b0;
        out_data     = '0;
        case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (r_wr_ptr == LAST)) begin
                    w_next_state = S_SORT;
                end
            end
            S_SORT: begin
                busy = 1'b1;
                if (r_phase == LAST) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = r_buf[r_rd_ptr];
                out_last  = (r_rd_ptr == LAST);
                if (out_ready && (r_rd_ptr == LAST)) begin
                    w_next_state = S_LOAD;
                end
            end
            default: w_next_state = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_buf[k] <= '0;
            end
            r_wr_ptr <= '0;
            r_phase  <= '0;
            r_rd_ptr <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_phase <= '0;
                    if (in_valid) begin
                        r_buf[r_wr_ptr] <= in_data;
                        r_wr_ptr        <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
                    end
                end
                S_SORT: begin
                    r_buf    <= w_sorted;
                    r_phase  <= (r_phase == LAST) ? '0 : r_phase + 1'b1;
                    r_rd_ptr <= '0;
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
                        if (r_rd_ptr == LAST) begin
                            r_wr_ptr <= '0;
                        end
                    end
                end
                default: begin
                    r_wr_ptr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_frame_serial.sv
// Bench for sort_frame_serial: three instances (4/UP, 4/DOWN, 8/UP) checked
// every cycle against a frame-level sorting model plus literal frame results.
module tb_sort_frame_serial;

  localparam int W = 64;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [N-1:0] in_valid;
  logic [N-1:0] out_ready;
  logic [W-1:0] in_data [N];
  wire  [N-1:0] in_ready;
  wire  [N-1:0] out_valid;
  wire  [N-1:0] out_last;
  wire  [N-1:0] busy;
  wire  [W-1:0] out_data [N];
  wire  [1:0]   dbg_state [N];

  int dep [N] = '{4, 4, 8};
  bit up  [N] = '{1'b1, 1'b0, 1'b1};

  int total = 0;
  int bad = 0;

  // model state
  int m_sort  [N];
  int m_drain [N];
  logic [W-1:0] frm_q [N][$];
  logic [W-1:0] exp_q [N][$];
  logic [W-1:0] got_q [N][$];
  logic [W-1:0] tmp_q [$];

  int rdy_mode [N];
  int pc [N];
  bit [3:0] pat = 4'b1001;

  always #5 clk = ~clk;

  sort_frame_serial #(.DATA_WIDTH(W), .DEPTH(4), .COM_STYLE("UP")) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_last(out_last[0]), .busy(busy[0]), .dbg_state(dbg_state[0])
  );

  sort_frame_serial #(.DATA_WIDTH(W), .DEPTH(4), .COM_STYLE("DOWN")) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_last(out_last[1]), .busy(busy[1]), .dbg_state(dbg_state[1])
  );

  sort_frame_serial #(.DATA_WIDTH(W), .DEPTH(8), .COM_STYLE("UP")) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .out_last(out_last[2]), .busy(busy[2]), .dbg_state(dbg_state[2])
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // compare process: model advances once per cycle on the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        chk($sformatf("rst_in_ready%0d", i), 64'(in_ready[i]), 64'd1);
        chk($sformatf("rst_out_valid%0d", i), 64'(out_valid[i]), 64'd0);
        chk($sformatf("rst_out_last%0d", i), 64'(out_last[i]), 64'd0);
        chk($sformatf("rst_busy%0d", i), 64'(busy[i]), 64'd0);
        chk($sformatf("rst_out_data%0d", i), out_data[i], 64'd0);
        m_sort[i] = 0;
        m_drain[i] = 0;
        frm_q[i].delete();
        exp_q[i].delete();
      end else begin
        bit exp_ir;
        exp_ir = (m_sort[i] == 0) && (m_drain[i] == 0);
        chk($sformatf("in_ready%0d", i), 64'(in_ready[i]), 64'(exp_ir));
        chk($sformatf("busy%0d", i), 64'(busy[i]), 64'(!exp_ir));
        chk($sformatf("out_valid%0d", i), 64'(out_valid[i]), 64'(m_drain[i] > 0));
        if (m_drain[i] > 0) begin
          chk($sformatf("out_last%0d", i), 64'(out_last[i]), 64'(m_drain[i] == 1));
          if (exp_q[i].size() == 0) timeout_fail($sformatf("model_empty%0d", i));
          else chk($sformatf("out_data%0d", i), out_data[i], exp_q[i][0]);
        end
        if (exp_ir) begin
          if (in_valid[i]) begin
            frm_q[i].push_back(in_data[i]);
            if (frm_q[i].size() == dep[i]) begin
              tmp_q = frm_q[i];
              if (up[i]) tmp_q.sort();
              else tmp_q.rsort();
              foreach (tmp_q[k]) exp_q[i].push_back(tmp_q[k]);
              frm_q[i].delete();
              m_sort[i] = dep[i];
            end
          end
        end else if (m_sort[i] > 0) begin
          m_sort[i]--;
          if (m_sort[i] == 0) m_drain[i] = dep[i];
        end else if (out_ready[i]) begin
          got_q[i].push_back(out_data[i]);
          if (exp_q[i].size() != 0) void'(exp_q[i].pop_front());
          m_drain[i]--;
        end
      end
    end
  end

  // downstream ready driver: 0 always, 1 pattern 1,0,0,1, 2 random, 3 stalled
  initial begin
    out_ready = '1;
    foreach (pc[i]) pc[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        case (rdy_mode[i])
          1: begin
            if (out_valid[i]) begin
              out_ready[i] = pat[pc[i] % 4];
              pc[i]++;
            end else begin
              out_ready[i] = 1'b1;
              pc[i] = 0;
            end
          end
          2: out_ready[i] = 1'($urandom_range(0, 1));
          3: out_ready[i] = 1'b0;
          default: out_ready[i] = 1'b1;
        endcase
      end
    end
  end

  task automatic send_word(input int i, input logic [W-1:0] w);
    int n;
    n = 0;
    in_valid[i] = 1'b1;
    in_data[i] = w;
    while (!in_ready[i] && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) timeout_fail($sformatf("send%0d", i));
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
  endtask

  task automatic measure_latency(input int i, output int lat);
    lat = 1;
    while (!out_valid[i] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic wait_done(input int i);
    int n;
    n = 0;
    while ((busy[i] || exp_q[i].size() != 0) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) timeout_fail($sformatf("drain%0d", i));
  endtask

  // junk word offered the whole time the block is busy; must never be taken
  task automatic hold_junk(input int i);
    int n;
    n = 0;
    in_valid[i] = 1'b1;
    in_data[i] = 64'hDEAD_BEEF_0BAD_F00D;
    while (busy[i] && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) timeout_fail($sformatf("junk%0d", i));
    in_valid[i] = 1'b0;
  endtask

  task automatic chk_got(input int i, input string nm, input logic [W-1:0] lit [8], input int n);
    chk({nm, "_count"}, 64'(got_q[i].size()), 64'(n));
    for (int k = 0; k < n && k < got_q[i].size(); k++)
      chk($sformatf("%s_w%0d", nm, k), got_q[i][k], lit[k]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [W-1:0] lit [8];
    in_valid = '0;
    foreach (in_data[i]) in_data[i] = '0;
    foreach (rdy_mode[i]) rdy_mode[i] = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ascending, depth 4
    got_q[0].delete();
    send_word(0, 9); send_word(0, 3); send_word(0, 7); send_word(0, 1);
    measure_latency(0, lat);
    chk("lat_up4", 64'(lat), 64'd5);
    wait_done(0);
    lit = '{64'd1, 64'd3, 64'd7, 64'd9, 64'd0, 64'd0, 64'd0, 64'd0};
    chk_got(0, "up4", lit, 4);

    // descending with ties, stalled drain, input held valid throughout
    got_q[1].delete();
    rdy_mode[1] = 1;
    send_word(1, 2); send_word(1, 8); send_word(1, 8); send_word(1, 5);
    hold_junk(1);
    wait_done(1);
    lit = '{64'd8, 64'd8, 64'd5, 64'd2, 64'd0, 64'd0, 64'd0, 64'd0};
    chk_got(1, "down4", lit, 4);
    rdy_mode[1] = 0;

    // worst case reversed frame, depth 8
    got_q[2].delete();
    for (int k = 8; k >= 1; k--) send_word(2, 64'(k));
    measure_latency(2, lat);
    chk("lat_up8", 64'(lat), 64'd9);
    wait_done(2);
    lit = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd8};
    chk_got(2, "up8", lit, 8);

    // reset with a partial frame in dut0 and a stalled drain in dut1
    rdy_mode[1] = 3;
    send_word(1, 40); send_word(1, 10); send_word(1, 30); send_word(1, 20);
    measure_latency(1, lat);
    send_word(0, 11); send_word(0, 12);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid1", 64'(out_valid[1]), 64'd0);
    chk("async_rst_busy1", 64'(busy[1]), 64'd0);
    chk("async_rst_in_ready1", 64'(in_ready[1]), 64'd1);
    chk("async_rst_in_ready0", 64'(in_ready[0]), 64'd1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_mode[1] = 0;
    got_q[0].delete();
    send_word(0, 4); send_word(0, 2); send_word(0, 3); send_word(0, 1);
    wait_done(0);
    lit = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd0, 64'd0, 64'd0, 64'd0};
    chk_got(0, "rst_up4", lit, 4);

    // back-to-back frames, second frame offered while the first drains
    got_q[0].delete();
    send_word(0, 5); send_word(0, 6); send_word(0, 7); send_word(0, 8);
    send_word(0, 0); send_word(0, 0); send_word(0, 0); send_word(0, 1);
    wait_done(0);
    lit = '{64'd5, 64'd6, 64'd7, 64'd8, 64'd0, 64'd0, 64'd0, 64'd1};
    chk_got(0, "b2b", lit, 8);

    // randomized frames with input gaps and random backpressure
    for (int i = 0; i < N; i++) begin
      rdy_mode[i] = 2;
      for (int f = 0; f < 6; f++) begin
        for (int k = 0; k < dep[i]; k++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          if ($urandom_range(0, 1) == 1) send_word(i, 64'($urandom_range(0, 3)));
          else send_word(i, {$urandom, $urandom});
        end
      end
      wait_done(i);
      rdy_mode[i] = 0;
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sort_frame_serial.md
# sort_frame_serial

Frame sorter that collects a frame of `DEPTH` unsigned words from a valid/ready stream, sorts the frame in place with an odd-even transposition network, and streams the sorted words out. It sits at the ingress/egress boundary of the ordering datapath. It is the stream-facing producer and consumer for the team's combinational compare element: it feeds word pairs in and collects the ordered results.

## Interface
- `DATA_WIDTH`, 64, word width in bits; words are compared as unsigned values.
- `DEPTH`, 8, words per frame; must be even and ≥ 4.
- `COM_STYLE`, "UP", sort order. "UP" is ascending: smallest word leaves first. "DOWN" is descending.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  block accepts an input word this cycle.
- `in_data`  in  DATA_WIDTH  input word.
- `out_valid`  out  1  sorted output word valid.
- `out_ready`  in  1  downstream accepts the output word.
- `out_data`  out  DATA_WIDTH  sorted output word.
- `out_last`  out  1  current output word is the final word of the frame.
- `busy`  out  1  block is in SORT or DRAIN.

## Operation
- The buffer `buf[0..DEPTH-1]` is DATA_WIDTH-wide registers. Frame counter `wr_ptr`, phase counter `phase` and read pointer `rd_ptr` are each $clog2(DEPTH) bits.
- FSM states: LOAD, SORT, DRAIN. Reset state is LOAD.
- LOAD:
  - `in_ready`=1.
  - On `in_valid && in_ready`: `buf[wr_ptr]<=in_data`, then `wr_ptr++`.
  - The accept with `wr_ptr==DEPTH-1` moves the FSM to SORT with `phase=0`.
- SORT:
  - One phase per cycle; `in_ready`=0.
  - Even phase: compare-exchange pairs (0,1),(2,3)…(DEPTH-2,DEPTH-1).
  - Odd phase: compare-exchange pairs (1,2)…(DEPTH-3,DEPTH-2); `buf[0]` and `buf[DEPTH-1]` hold.
  - Exchange rule for pair (i,i+1): "UP" puts the lower value in i; "DOWN" puts the higher value in i.
  - Equal words are not swapped.
  - After the phase with `phase==DEPTH-1`, the FSM moves to DRAIN with `rd_ptr=0`.
- DRAIN:
  - `out_valid`=1, `out_data=buf[rd_ptr]`, `out_last=(rd_ptr==DEPTH-1)`.
  - On `out_valid && out_ready`: `rd_ptr++`.
  - The transfer with `out_last`=1 returns the FSM to LOAD with `wr_ptr=0`.
- Outside LOAD, `in_valid` is ignored and no word is lost; the source holds the word because `in_ready`=0.
- `out_data` and `out_last` stay stable while `out_valid && !out_ready`.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_last`=0, `busy`=0, `out_data`=0. All of `buf`, pointers and `phase` are 0.
- Reset asserted mid-frame, in any state, discards the partial frame. The block is back in LOAD immediately, asynchronously.
- Latency: last input accepted at edge t → SORT during cycles t+1…t+DEPTH → `out_valid`=1 in cycle t+DEPTH+1.
- Throughput: one frame per 2·DEPTH+DEPTH cycles when neither side stalls. Load and drain do not overlap.
- `in_ready`, `out_valid`, `out_last` and `busy` decode directly from state registers; none is combinationally dependent on `in_valid` or `out_ready`.
- `busy`=1 exactly in SORT and DRAIN.
- Back-to-back frames: the cycle after the final DRAIN transfer has `in_ready`=1.

## Structure
- Package `sort_pkg` holds:
  - State encoding localparams `ST_LOAD`, `ST_SORT`, `ST_DRAIN`.
  - A function returning $clog2(DEPTH).
  - The `COM_STYLE` string constants.
- Sub-module: the team's combinational compare element `com_logic`, with DEPTH/2 instances for the even bank and DEPTH/2−1 for the odd bank.
  - Its `COM_STYLE` is passed through.
  - A per-slot mux on `phase[0]` selects the bank result for write-back.

## Test plan
- DEPTH=4, UP: load 9,3,7,1 → out 1,3,7,9; `out_last` only with 9. First `out_valid` is 5 cycles after the accept of 1.
- DEPTH=4, DOWN: load 2,8,8,5 → out 8,8,5,2. Equal words produce no X, and the output holds while stalled.
- DEPTH=8, UP, worst case 8,7,6,5,4,3,2,1 → 1…8 after exactly 8 SORT cycles.
- Backpressure: `out_ready` toggles 1,0,0,1 during DRAIN → `out_data` holds across stalls. With `in_valid`=1 throughout SORT/DRAIN, `in_ready`=0 and no extra word is captured.
- Reset after 2 of 4 words loaded → `in_ready`=1 and `out_valid`=0. The next full frame 4,2,3,1 gives 1,2,3,4 with no stale words.
- Back-to-back frames 5,6,7,8 then 0,0,0,1: second frame accepted the cycle after the first frame's `out_last` transfer → out 0,0,0,1.
